alu_arbiter: RTL

Shares the single combinational ALU between two requesters, requester 0 (pipeline EXE stage) and requester 1 (the multi-cycle/auxiliary unit). Each requester uses a valid/ready request and a valid/ready response. A three-state FSM with a round-robin priority pointer sequences one operation at a time: capture operands, drive the ALU from registers, then hold the registered result until the owner accepts it. The block sits between the requesters and the ALU's `val1`/`val2`/`EXE_CMD`/`ALU_result` ports.

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between requester 0 (EXE stage)
// and requester 1 (multi-cycle/auxiliary unit). A three-state FSM
// (IDLE -> EXEC -> RESP) runs one operation at a time. A round-robin priority
// bit picks the winner when both requesters ask in the same cycle.
// Optional feature macro: ALU_ARB_ILLEGAL_CHK_EN. When it is defined, an
// illegal command is accepted but runs as 0000. Its result is then forced to
// 0 and rsp_err is set for that response.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CMD_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_val1,
   input  logic [WIDTH-1:0] req0_val2,
   input  logic [CMD_W-1:0] req0_cmd,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_val1,
   input  logic [WIDTH-1:0] req1_val2,
   input  logic [CMD_W-1:0] req1_cmd,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_val1,
   output logic [WIDTH-1:0] alu_val2,
   output logic [CMD_W-1:0] alu_cmd,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] val1_q, val1_d;
   logic [WIDTH-1:0] val2_q, val2_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic             gnt1;
   logic [CMD_W-1:0] cmd_in;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
   logic             ill_q, ill_d;

   // Legal ALU commands: add, sub, and, or, nor, xor, sll, sra, srl.
   function automatic logic is_legal(input logic [CMD_W-1:0] cmd);
      is_legal = (cmd == CMD_W'(0)) || (cmd == CMD_W'(2)) || (cmd == CMD_W'(4)) ||
                 (cmd == CMD_W'(5)) || (cmd == CMD_W'(6)) || (cmd == CMD_W'(7)) ||
                 (cmd == CMD_W'(8)) || (cmd == CMD_W'(9)) || (cmd == CMD_W'(10));
   endfunction
`endif

   assign alu_val1   = val1_q;
   assign alu_val2   = val2_q;
   assign alu_cmd    = cmd_q;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;

   // Next-state logic: arbitration, operand capture, result capture, response release.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      owner_d      = owner_q;
      val1_d       = val1_q;
      val2_d       = val2_q;
      cmd_d        = cmd_q;
      result_d     = result_q;
      err_d        = err_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      gnt1         = req1_valid && (!req0_valid || prio_q);
      cmd_in       = gnt1 ? req1_cmd : req0_cmd;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      ill_d        = ill_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready = !gnt1;
               req1_ready = gnt1;
               owner_d    = gnt1;
               prio_d     = !gnt1;
               val1_d     = gnt1 ? req1_val1 : req0_val1;
               val2_d     = gnt1 ? req1_val2 : req0_val2;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
               ill_d      = !is_legal(cmd_in);
               cmd_d      = is_legal(cmd_in) ? cmd_in : '0;
`else
               cmd_d      = cmd_in;
`endif
               state_d    = EXEC;
            end
         end
         EXEC: begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            result_d = ill_q ? '0 : alu_result;
            err_d    = ill_q;
`else
            result_d = alu_result;
            err_d    = 1'b0;
`endif
            rsp0_valid_d = !owner_q;
            rsp1_valid_d = owner_q;
            state_d      = RESP;
         end
         RESP: begin
            if ((!owner_q && rsp0_ready) || (owner_q && rsp1_ready)) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         owner_q      <= 1'b0;
         val1_q       <= '0;
         val2_q       <= '0;
         cmd_q        <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
         ill_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         owner_q      <= owner_d;
         val1_q       <= val1_d;
         val2_q       <= val2_d;
         cmd_q        <= cmd_d;
         result_q     <= result_d;
         err_q        <= err_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
         ill_q        <= ill_d;
`endif
      end
   end

endmodule
